// File: rtl/jpc_pkg.sv
// Shared decode definitions: opcode constants, instruction class enum and
// the decoded-entry record held in the decode queue.
package jpc_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_R   = 4'd0,
        ALU_I   = 4'd1,
        LOAD    = 4'd2,
        STORE   = 4'd3,
        BRANCH  = 4'd4,
        JAL     = 4'd5,
        JALR    = 4'd6,
        LUI     = 4'd7,
        AUIPC   = 4'd8,
        FENCE   = 4'd9,
        SYSTEM  = 4'd10,
        CSR     = 4'd11,
        ILLEGAL = 4'd12
    } jpc_class_e;

    // Every immediate (including a zero-extended CSR address) fits in 32
    // signed bits, so the entry keeps 32 bits and the queue sign-extends
    // to XLEN on the way out.
    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        jpc_class_e  cls;
        logic        ecall;
        logic        ebreak;
        logic        fence;
        logic        fence_i;
        logic        illegal;
    } dec_entry_t;

endpackage

// File: rtl/jpc_idecode_core.sv
// Combinational RV32/64 base instruction decode: field and immediate
// extraction plus legality. Build option: JPC_ZICSR_EN makes the CSR
// SYSTEM encodings legal (class CSR, imm = zero-extended csr address).
module jpc_idecode_core
    import jpc_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_entry_t  entry_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'h000};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Classify by opcode, then squash immediate and flags if the encoding is illegal
    always_comb begin
        logic bad;
        bad             = 1'b0;
        entry_o         = '0;
        entry_o.rs1     = instr_i[19:15];
        entry_o.rs2     = instr_i[24:20];
        entry_o.rd      = instr_i[11:7];
        entry_o.opcode  = opcode;
        entry_o.funct3  = funct3;
        entry_o.funct7  = instr_i[31:25];
        entry_o.cls     = ILLEGAL;
        case (opcode)
            OPC_OP:     entry_o.cls = ALU_R;
            OPC_OP_IMM: begin entry_o.cls = ALU_I;  entry_o.imm = imm_i; end
            OPC_LOAD:   begin entry_o.cls = LOAD;   entry_o.imm = imm_i; end
            OPC_STORE:  begin entry_o.cls = STORE;  entry_o.imm = imm_s; end
            OPC_BRANCH: begin entry_o.cls = BRANCH; entry_o.imm = imm_b; end
            OPC_LUI:    begin entry_o.cls = LUI;    entry_o.imm = imm_u; end
            OPC_AUIPC:  begin entry_o.cls = AUIPC;  entry_o.imm = imm_u; end
            OPC_JAL:    begin entry_o.cls = JAL;    entry_o.imm = imm_j; end
            OPC_JALR: begin
                entry_o.cls = JALR;
                entry_o.imm = imm_i;
                bad         = (funct3 != 3'b000);
            end
            OPC_MISC_MEM: begin
                entry_o.cls     = FENCE;
                entry_o.imm     = imm_i;
                entry_o.fence   = (funct3 == 3'b000);
                entry_o.fence_i = (funct3 == 3'b001);
                bad             = (funct3[2:1] != 2'b00);
            end
            OPC_SYSTEM: begin
                entry_o.cls = SYSTEM;
                case (funct3)
                    3'b000: begin
                        if (instr_i[31:20] == 12'd0) begin
                            entry_o.ecall = 1'b1;
                        end else if (instr_i[31:20] == 12'd1) begin
                            entry_o.ebreak = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    3'b100: bad = 1'b1;
                    default: begin
`ifdef JPC_ZICSR_EN
                        entry_o.cls = CSR;
                        entry_o.imm = {20'h00000, instr_i[31:20]};
`else
                        bad = 1'b1;
`endif
                    end
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            entry_o.cls     = ILLEGAL;
            entry_o.imm     = '0;
            entry_o.ecall   = 1'b0;
            entry_o.ebreak  = 1'b0;
            entry_o.fence   = 1'b0;
            entry_o.fence_i = 1'b0;
            entry_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/jpc_idecode_q.sv
// Decode stage with a DEPTH-entry show-ahead queue of decoded instructions
// and a saturating illegal-instruction counter. Build option JPC_ZICSR_EN
// is consumed by jpc_idecode_core.
module jpc_idecode_q
    import jpc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_I,
    input  logic             rst_I,
    input  logic             instr_valid_I,
    output logic             instr_ready_O,
    input  logic [31:0]      instr_I,
    input  logic [XLEN-1:0]  pc_I,
    input  logic             flush_I,
    output logic             dec_valid_O,
    input  logic             dec_ready_I,
    output logic [XLEN-1:0]  dec_pc_O,
    output logic [XLEN-1:0]  dec_imm_O,
    output logic [4:0]       dec_rs1_O,
    output logic [4:0]       dec_rs2_O,
    output logic [4:0]       dec_rd_O,
    output logic [6:0]       dec_opcode_O,
    output logic [2:0]       dec_funct3_O,
    output logic [6:0]       dec_funct7_O,
    output logic [3:0]       dec_class_O,
    output logic             dec_ecall_O,
    output logic             dec_ebreak_O,
    output logic             dec_fence_O,
    output logic             dec_fence_i_O,
    output logic             dec_illegal_O,
    output logic [CNT_W-1:0] illegal_cnt_O
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    dec_entry_t       new_entry;
    dec_entry_t       head;
    dec_entry_t       entry_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    jpc_idecode_core u_core (
        .instr_i (instr_I),
        .entry_o (new_entry)
    );

    // Extra pointer MSB separates full (MSBs differ) from empty (equal)
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign instr_ready_O = !full;
    assign dec_valid_O   = !empty;
    assign push          = instr_valid_I && instr_ready_O && !flush_I;
    assign pop           = dec_valid_O && dec_ready_I;

    // Next pointers and counter; flush drops everything, queued or offered
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_I) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
        if (push && new_entry.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset wins over every other action
    always_ff @(posedge clk_I) begin
        if (rst_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Queue storage is not reset; validity comes from the pointers alone
    always_ff @(posedge clk_I) begin
        if (push) begin
            entry_mem[wr_ptr_q[AW-1:0]] <= new_entry;
            pc_mem[wr_ptr_q[AW-1:0]]    <= pc_I;
        end
    end

    assign head          = entry_mem[rd_ptr_q[AW-1:0]];
    assign dec_pc_O      = pc_mem[rd_ptr_q[AW-1:0]];
    assign dec_imm_O     = XLEN'($signed(head.imm));
    assign dec_rs1_O     = head.rs1;
    assign dec_rs2_O     = head.rs2;
    assign dec_rd_O      = head.rd;
    assign dec_opcode_O  = head.opcode;
    assign dec_funct3_O  = head.funct3;
    assign dec_funct7_O  = head.funct7;
    assign dec_class_O   = head.cls;
    assign dec_ecall_O   = dec_valid_O && head.ecall;
    assign dec_ebreak_O  = dec_valid_O && head.ebreak;
    assign dec_fence_O   = dec_valid_O && head.fence;
    assign dec_fence_i_O = dec_valid_O && head.fence_i;
    assign dec_illegal_O = dec_valid_O && head.illegal;
    assign illegal_cnt_O = cnt_q;

endmodule

// File: doc/jpc_idecode_q.md
JPC_IDECODE_Q -- requirements
Module: jpc_idecode_q

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width: 32 or 64; immediates and pc are sign-extended to XLEN.
REQ-002 SHALL have parameter DEPTH, default 2, meaning decoded-entry queue depth: a power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 16, meaning illegal-instruction counter width.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk_I  in  1  rising-edge clock.
REQ-005 rst_I  in  1  synchronous active-high reset.
REQ-006 instr_valid_I  in  1  upstream instruction valid.
REQ-007 instr_ready_O  out  1  stage can accept an instruction.
REQ-008 instr_I  in  32  raw instruction.
REQ-009 pc_I  in  XLEN  instruction address.
REQ-010 flush_I  in  1  discard all queued entries.
REQ-011 dec_valid_O  out  1  head entry valid.
REQ-012 dec_ready_I  in  1  downstream consumes head.
REQ-013 dec_pc_O, dec_imm_O  out  XLEN  pc and immediate of head.
REQ-014 dec_rs1_O, dec_rs2_O, dec_rd_O  out  5 each  register fields; dec_opcode_O 7, dec_funct3_O 3, dec_funct7_O 7.
REQ-015 dec_class_O  out  4  instruction class (package enum).
REQ-016 dec_ecall_O, dec_ebreak_O, dec_fence_O, dec_fence_i_O, dec_illegal_O  out  1 each  head flags.
REQ-017 illegal_cnt_O  out  CNT_W  saturating count of illegal instructions accepted.

Function
REQ-018 Push condition SHALL be instr_valid_I && instr_ready_O && !flush_I; pop condition SHALL be dec_valid_O && dec_ready_I.
REQ-019 instr_ready_O SHALL be !full; no same-cycle pass-through when full, even if a pop occurs that cycle.
REQ-020 Simultaneous push and pop on a non-full, non-empty queue SHALL leave occupancy unchanged.
REQ-021 Latency SHALL be 1 cycle: an instruction pushed into an empty queue at edge N is presented at dec_* after edge N.
REQ-022 Entries SHALL be output in FIFO order; read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-023 Legal opcodes SHALL be OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (funct3 must be 000), MISC-MEM 0001111 (funct3 000 sets fence, 001 sets fence_i), and SYSTEM 1110011.
REQ-024 For SYSTEM with funct3=000: imm12=0 SHALL set ecall; imm12=1 SHALL set ebreak; any other value SHALL be illegal.
REQ-025 Immediates SHALL be I/S/B/U/J per the RISC-V base ISA, sign-extended to XLEN; R-type and SYSTEM SHALL give imm 0.
REQ-026 An illegal instruction SHALL still be queued with dec_illegal_O=1, imm=0 and class ILLEGAL; the stage SHALL NOT stall on it.
REQ-027 illegal_cnt_O SHALL increment on each pushed illegal entry and saturate at all-ones.
REQ-028 flush_I SHALL empty the queue at the next edge, with dec_valid_O=0 the following cycle; an input offered in the flush cycle SHALL be dropped and not counted; the counter SHALL NOT clear on flush.
REQ-029 While dec_valid_O=0, dec_* data SHALL be don't-care; flags SHALL be 0.

Reset
REQ-030 rst_I SHALL clear the pointers, set dec_valid_O=0, set instr_ready_O=1, set illegal_cnt_O=0 and drive all dec_* flags to 0; queue storage need not be reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries at that edge and take priority over push, pop and flush.

Configuration
REQ-032 With macro JPC_ZICSR_EN defined, SYSTEM funct3 in {001,010,011,101,110,111} SHALL be legal with class CSR and imm = zero-extended csr address (instr[31:20]); without it, those encodings SHALL be illegal.
REQ-033 SYSTEM funct3=100 SHALL be illegal in both builds.

Structure
REQ-034 The opcode constants, the class enum (ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM, CSR, ILLEGAL) and the decoded-entry struct SHALL reside in jpc_pkg.
REQ-035 Combinational field and immediate extraction SHALL be the sub-module jpc_idecode_core; jpc_idecode_q SHALL own the queue, handshake and counter.

Verification
REQ-036 Push 0x00500093 (addi x1,x0,5) into an empty queue -> next cycle dec_valid_O=1, class ALU_I, rd=1, imm=5.
REQ-037 Push 0xFE000EE3 (beq, offset -4) with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
REQ-038 Hold dec_ready_I=0 and push DEPTH entries -> instr_ready_O=0; the next offer is not accepted; a single pop restores instr_ready_O=1 the following cycle.
REQ-039 Push 0x00000000, 0x00100073 and 0x30200073 -> illegal, ebreak, and mret-encoding illegal respectively; illegal_cnt_O=2.
REQ-040 Push 0x30002573 (csrr) -> class CSR with imm=0x300 when JPC_ZICSR_EN is defined; dec_illegal_O=1 when it is not.
REQ-041 With 2 entries queued, assert flush_I together with a valid input -> queue empties, the input is dropped, and the counter is unchanged; assert rst_I with the counter at max -> illegal_cnt_O=0.
